// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with a two-entry skid buffer and flush.
// Carries a payload plus an rd forwarding tap qualified by out_valid.
module pipe_stage_hs #(
  parameter int unsigned DW = 64,
  parameter logic [DW-1:0] RESET_VAL = '0,
  parameter int unsigned IDX_W = 5,
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_rd_en,
  input  logic [IDX_W-1:0] in_rd_idx,
  input  logic [XLEN-1:0]  in_rd_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_rd_en,
  output logic [IDX_W-1:0] out_rd_idx,
  output logic [XLEN-1:0]  out_rd_wdata,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic [XLEN-1:0]  rd_wdata;
  } beat_t;

  logic [1:0] state;
  logic [1:0] state_nxt;
  beat_t      main_q;
  beat_t      skid_q;
  beat_t      in_beat;
  logic       push;
  logic       pop;
  logic       main_ld_in;
  logic       main_ld_skid;
  logic       skid_ld;

  assign in_beat.data     = in_data;
  assign in_beat.rd_en    = in_rd_en;
  assign in_beat.rd_idx   = in_rd_idx;
  assign in_beat.rd_wdata = in_rd_wdata;

  // in_ready never looks at out_ready: no combinational path upstream
  assign in_ready  = (state != S_FULL) & ~flush & ~rst;
  assign out_valid = (state != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data     = main_q.data;
  assign out_rd_en    = main_q.rd_en & out_valid;
  assign out_rd_idx   = main_q.rd_idx;
  assign out_rd_wdata = main_q.rd_wdata;
  assign occupancy    = state;

  always_comb begin
    state_nxt    = state;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (push) begin
            state_nxt  = S_ONE;
            main_ld_in = 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            main_ld_in = 1'b1;
          end else if (push) begin
            state_nxt = S_FULL;
            skid_ld   = 1'b1;
          end else if (pop) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_nxt    = S_ONE;
            main_ld_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_EMPTY;
      main_q.data     <= RESET_VAL;
      main_q.rd_en    <= 1'b0;
      main_q.rd_idx   <= '0;
      main_q.rd_wdata <= '0;
      skid_q          <= '0;
    end else begin
      state <= state_nxt;
      if (main_ld_in) begin
        main_q <= in_beat;
      end else if (main_ld_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= in_beat;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: reset, streaming, stall,
// push/pop overlap, flush and forwarding tap.
module tb_pipe_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_rd_en;
  logic [4:0]  in_rd_idx;
  logic [31:0] in_rd_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_rd_en;
  logic [4:0]  out_rd_idx;
  logic [31:0] out_rd_wdata;
  logic [1:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stage_hs dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_rd_en(in_rd_en),
    .in_rd_idx(in_rd_idx),
    .in_rd_wdata(in_rd_wdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_rd_en(out_rd_en),
    .out_rd_idx(out_rd_idx),
    .out_rd_wdata(out_rd_wdata),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_rd_en = 1'b0;
    in_rd_idx = '0;
    in_rd_wdata = '0;
    drive(1'b1, 64'hAA);

    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_data", out_data, 64'd0);
      check("rst_rd_en", 64'(out_rd_en), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end
    rst = 1'b0;
    drive(1'b0, 64'h0);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // streaming
    out_ready = 1'b1;
    drive(1'b1, 64'h11); tick();
    check("st_d0", out_data, 64'h11);
    check("st_occ0", 64'(occupancy), 64'd1);
    drive(1'b1, 64'h22); tick();
    check("st_d1", out_data, 64'h22);
    check("st_occ1", 64'(occupancy), 64'd1);
    drive(1'b1, 64'h33); tick();
    check("st_d2", out_data, 64'h33);
    check("st_occ2", 64'(occupancy), 64'd1);
    check("st_v2", 64'(out_valid), 64'd1);
    drive(1'b0, 64'h0); tick();
    check("st_drain", 64'(out_valid), 64'd0);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 64'h11); tick();
    check("bp_occ1", 64'(occupancy), 64'd1);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    drive(1'b1, 64'h22); tick();
    check("bp_occ2", 64'(occupancy), 64'd2);
    check("bp_rdy2", 64'(in_ready), 64'd0);
    check("bp_head", out_data, 64'h11);
    drive(1'b0, 64'h0); tick();
    check("bp_hold", out_data, 64'h11);
    check("bp_hold_occ", 64'(occupancy), 64'd2);
    out_ready = 1'b1; tick();
    check("bp_pop1", out_data, 64'h22);
    check("bp_pop1_occ", 64'(occupancy), 64'd1);
    check("bp_pop1_rdy", 64'(in_ready), 64'd1);
    tick();
    check("bp_pop2", 64'(out_valid), 64'd0);

    // simultaneous push/pop in ONE
    out_ready = 1'b0;
    drive(1'b1, 64'h11); tick();
    check("pp_head", out_data, 64'h11);
    out_ready = 1'b1;
    drive(1'b1, 64'h22); tick();
    check("pp_occ", 64'(occupancy), 64'd1);
    check("pp_data", out_data, 64'h22);
    drive(1'b0, 64'h0); tick();
    check("pp_drain", 64'(occupancy), 64'd0);

    // flush while full
    out_ready = 1'b0;
    drive(1'b1, 64'h11); tick();
    drive(1'b1, 64'h22); tick();
    check("fl_full", 64'(occupancy), 64'd2);
    drive(1'b1, 64'h33);
    flush = 1'b1;
    #1;
    check("fl_rdy", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0;
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_occ", 64'(occupancy), 64'd0);
    drive(1'b1, 64'h44);
    #1;
    check("fl_rdy_back", 64'(in_ready), 64'd1);
    tick();
    check("fl_next", out_data, 64'h44);
    check("fl_next_occ", 64'(occupancy), 64'd1);
    out_ready = 1'b1;
    drive(1'b0, 64'h0); tick();
    check("fl_drain", 64'(out_valid), 64'd0);

    // forwarding tap
    out_ready = 1'b0;
    in_rd_en = 1'b1;
    in_rd_idx = 5'd5;
    in_rd_wdata = 32'hDEADBEEF;
    drive(1'b1, 64'h55); tick();
    check("fw_en", 64'(out_rd_en), 64'd1);
    check("fw_idx", 64'(out_rd_idx), 64'd5);
    check("fw_wd", 64'(out_rd_wdata), 64'hDEADBEEF);
    in_rd_en = 1'b0;
    in_rd_idx = 5'd0;
    in_rd_wdata = '0;
    drive(1'b0, 64'h0);
    out_ready = 1'b1; tick();
    check("fw_drain_en", 64'(out_rd_en), 64'd0);
    check("fw_drain_idx", 64'(out_rd_idx), 64'd5);
    out_ready = 1'b0;
    in_rd_en = 1'b1;
    in_rd_idx = 5'd5;
    drive(1'b1, 64'h66); tick();
    check("fw_en2", 64'(out_rd_en), 64'd1);
    in_rd_en = 1'b0;
    drive(1'b0, 64'h0);
    flush = 1'b1; tick();
    flush = 1'b0;
    check("fw_flush_en", 64'(out_rd_en), 64'd0);
    check("fw_flush_idx", 64'(out_rd_idx), 64'd5);

    // reset mid-operation
    drive(1'b1, 64'h77); tick();
    check("mr_occ_pre", 64'(occupancy), 64'd1);
    rst = 1'b1;
    drive(1'b1, 64'h88); tick();
    rst = 1'b0;
    drive(1'b0, 64'h0);
    check("mr_occ", 64'(occupancy), 64'd0);
    check("mr_data", out_data, 64'd0);
    check("mr_idx", 64'(out_rd_idx), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
